ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the byte address of the first instruction fetched after reset.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-005 The block SHALL have the port imem_addr, output, 32 bits: byte address of the requested instruction; always equals pc.
REQ-006 The block SHALL have the port imem_ready, input, 1 bit: memory has the requested word on imem_rdata this cycle.
REQ-007 The block SHALL have the port imem_rdata, input, 32 bits: instruction word from memory.
REQ-008 The block SHALL have the port instr, output, 32 bits: held instruction for decode and datapath.
REQ-009 The block SHALL have the port opcode, output, 6 bits: instr[31:26], which drives the main controller's Opcode input.
REQ-010 The block SHALL have the port instr_valid, output, 1 bit: instr holds a fetched, not-yet-retired instruction.
REQ-011 The block SHALL have the port retire, input, 1 bit: the datapath has finished the held instruction.
REQ-012 The block SHALL have the ports Branch, Jump and Zero, inputs, 1 bit each: controller branch/jump decisions and the ALU zero flag for the held instruction.
REQ-013 The block SHALL have the port pc, output, 32 bits: address of the current instruction.
REQ-014 The block SHALL have the port pc_plus4, output, 32 bits: pc+4, combinational.
REQ-015 The block SHALL have the port retired_cnt, output, 32 bits: count of retired instructions.

Function
REQ-016 The FSM SHALL have three states: IDLE, FETCH and HOLD.
REQ-017 IDLE SHALL transition unconditionally to FETCH after one cycle.
REQ-018 FETCH SHALL drive imem_req=1; on an edge with imem_ready=1 it SHALL load instr<=imem_rdata and transition to HOLD; otherwise it SHALL stay in FETCH with pc unchanged.
REQ-019 HOLD SHALL drive instr_valid=1 and imem_req=0; on an edge with retire=1 it SHALL update pc<=npc, increment retired_cnt and transition to FETCH; otherwise instr and pc SHALL hold.
REQ-020 retire SHALL be ignored in IDLE and FETCH, and imem_ready SHALL be ignored outside FETCH.
REQ-021 npc priority SHALL be: Jump=1 gives {pc_plus4[31:28], instr[25:0], 2'b00}; else Branch=1 and Zero=1 gives pc_plus4 + (sign_extend(instr[15:0])<<2); else pc_plus4.
REQ-022 If Jump and Branch&Zero are both 1, Jump SHALL win.
REQ-023 Branch, Jump and Zero SHALL be sampled only at the retire edge.
REQ-024 All address arithmetic SHALL be 32-bit modulo 2^32; pc wrap from 32'hFFFF_FFFC to 0 is legal.
REQ-025 retired_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-026 Minimum throughput SHALL be one instruction per 2 cycles: FETCH with ready, then HOLD with retire.
REQ-027 opcode SHALL always equal instr[31:26].

Reset
REQ-028 While rst_n=0, outputs SHALL be: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired_cnt=0.
REQ-029 Reset asserted mid-FETCH or mid-HOLD SHALL abort immediately: imem_req and instr_valid drop without waiting for a clock, and any pending retire is lost.

Structure
REQ-030 Package ifu_pkg SHALL hold the state enum (IDLE/FETCH/HOLD), the RESET_PC default and the 32-bit width constants.
REQ-031 Next-PC computation SHALL be a purely combinational sub-module npc, instantiated once.

Verification
REQ-032 Reset release, imem_ready=1 and imem_rdata=32'h2008_0005 at the first FETCH -> imem_addr=0x3000; instr_valid=1 the next cycle; opcode=6'b001000.
REQ-033 HOLD, instr=32'h1000_0003, Branch=1, Zero=1, retire -> next imem_addr=0x3010.
REQ-034 HOLD at pc=0x3000, instr=32'h0800_0C40, Jump=1, Branch=1, Zero=1, retire -> pc=0x0000_3100 (Jump wins).
REQ-035 imem_ready held 0 for 5 cycles in FETCH -> imem_req stays 1, pc stable, instr_valid=0; retire pulses in that window -> no effect.
REQ-036 rst_n pulled low mid-HOLD with retire=1 -> instr_valid=0 and pc=0x3000 immediately, retired_cnt=0.
REQ-037 Branch=1, Zero=1, imm16=16'hFFFF at pc=0x3000 -> pc=0x3000 (backward branch via sign extension).

Source files
------------

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

  localparam int XLEN = 32;
  localparam int OPCODE_W = 6;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ifu_npc.sv
// rtl/ifu_npc.sv - combinational next-pc selection (jump > taken branch > sequential)
module npc
  import ifu_pkg::*;
(
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [25:0]     target,
  input  logic            branch,
  input  logic            jump,
  input  logic            zero,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] branch_offset;

  // word offset sign-extended and scaled to bytes; addition wraps modulo 2^32
  assign branch_offset = {{14{target[15]}}, target[15:0], 2'b00};

  // jump outranks a taken branch when both are asserted
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], target, 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_offset;
    end
  end

endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: fetch, hold until retire, advance pc
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        retire,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired_cnt
);

  ifu_state_e      state;
  logic [XLEN-1:0] next_pc;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign opcode    = instr[31:26];

  npc u_npc (
    .pc_plus4 (pc_plus4),
    .target   (instr[25:0]),
    .branch   (Branch),
    .jump     (Jump),
    .zero     (Zero),
    .next_pc  (next_pc)
  );

  // fetch/hold sequencer; imem_req and instr_valid are registered so reset clears them at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      retired_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            state       <= HOLD;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (retire) begin
            pc          <= next_pc;
            retired_cnt <= retired_cnt + 32'd1;
            state       <= FETCH;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - directed vector bench for the instruction fetch unit
module tb_ifu;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        retire;
  logic        Branch;
  logic        Jump;
  logic        Zero;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired_cnt;

  int n_vec;
  int n_err;

  ifu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .retire      (retire),
    .Branch      (Branch),
    .Jump        (Jump),
    .Zero        (Zero),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        branch;
    logic        jump;
    logic        zero;
    logic [5:0]  exp_opcode;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_ready = 1'b0;
    retire = 1'b0;
    Branch = 1'b0;
    Jump = 1'b0;
    Zero = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one clock step; inputs set before the call are seen at the edge, outputs sampled 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = '0;
    retire = 1'b0;
    Branch = 1'b0;
    Jump = 1'b0;
    Zero = 1'b0;

    vecs[0] = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 6'h08, 32'h0000_3004};
    vecs[1] = '{32'h1000_0003, 1'b1, 1'b0, 1'b1, 6'h04, 32'h0000_3010};
    vecs[2] = '{32'h0800_0C40, 1'b1, 1'b1, 1'b1, 6'h02, 32'h0000_3100};
    vecs[3] = '{32'h1000_FFFF, 1'b1, 1'b0, 1'b1, 6'h04, 32'h0000_3000};
    vecs[4] = '{32'h1000_0003, 1'b1, 1'b0, 1'b0, 6'h04, 32'h0000_3004};
    vecs[5] = '{32'h1000_0003, 1'b0, 1'b0, 1'b1, 6'h04, 32'h0000_3004};
    vecs[6] = '{32'h0BFF_FFFF, 1'b0, 1'b1, 1'b0, 6'h02, 32'h0FFF_FFFC};
    vecs[7] = '{32'h1000_8000, 1'b1, 1'b0, 1'b1, 6'h04, 32'hFFFE_3004};

    // reset values while rst_n is low
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_cnt", retired_cnt, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h0000_3004);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;

    // one fetch + retire per vector, each from a fresh reset at 0x3000
    for (int i = 0; i < 8; i++) begin
      do_reset();
      imem_ready = 1'b1;
      imem_rdata = vecs[i].rdata;
      step();
      check($sformatf("v%0d_req", i), {31'b0, imem_req}, 32'h1);
      check($sformatf("v%0d_addr", i), imem_addr, 32'h0000_3000);
      step();
      imem_ready = 1'b0;
      check($sformatf("v%0d_valid", i), {31'b0, instr_valid}, 32'h1);
      check($sformatf("v%0d_req_hold", i), {31'b0, imem_req}, 32'h0);
      check($sformatf("v%0d_opcode", i), {26'b0, opcode}, {26'b0, vecs[i].exp_opcode});
      check($sformatf("v%0d_instr", i), instr, vecs[i].rdata);
      Branch = vecs[i].branch;
      Jump = vecs[i].jump;
      Zero = vecs[i].zero;
      retire = 1'b1;
      step();
      retire = 1'b0;
      Branch = 1'b0;
      Jump = 1'b0;
      Zero = 1'b0;
      check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d_addr_next", i), imem_addr, vecs[i].exp_pc);
      check($sformatf("v%0d_cnt", i), retired_cnt, 32'h1);
      check($sformatf("v%0d_valid_after", i), {31'b0, instr_valid}, 32'h0);
    end

    // stall: ready low for 5 cycles, retire pulses ignored
    do_reset();
    imem_ready = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      retire = c[0];
      Jump = 1'b1;
      step();
      check($sformatf("stall%0d_req", c), {31'b0, imem_req}, 32'h1);
      check($sformatf("stall%0d_pc", c), pc, 32'h0000_3000);
      check($sformatf("stall%0d_valid", c), {31'b0, instr_valid}, 32'h0);
      check($sformatf("stall%0d_cnt", c), retired_cnt, 32'h0);
    end
    retire = 1'b0;
    Jump = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h2008_0005;
    step();
    check("stall_end_instr", instr, 32'h2008_0005);
    check("stall_end_valid", {31'b0, instr_valid}, 32'h1);

    // HOLD: ready/rdata ignored, Jump without retire has no effect
    imem_rdata = 32'hDEAD_BEEF;
    Jump = 1'b1;
    step();
    Jump = 1'b0;
    imem_ready = 1'b0;
    check("hold_instr_kept", instr, 32'h2008_0005);
    check("hold_pc_kept", pc, 32'h0000_3000);

    // back-to-back: two instructions in four cycles
    retire = 1'b1;
    step();
    retire = 1'b0;
    check("b2b_pc1", pc, 32'h0000_3004);
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0020;
    step();
    imem_ready = 1'b0;
    check("b2b_valid2", {31'b0, instr_valid}, 32'h1);
    retire = 1'b1;
    step();
    retire = 1'b0;
    check("b2b_pc2", pc, 32'h0000_3008);
    check("b2b_cnt2", retired_cnt, 32'h2);

    // reset mid-HOLD with retire pending
    imem_ready = 1'b1;
    imem_rdata = 32'h1000_0003;
    step();
    imem_ready = 1'b0;
    check("mid_valid_pre", {31'b0, instr_valid}, 32'h1);
    retire = 1'b1;
    Branch = 1'b1;
    Zero = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, instr_valid}, 32'h0);
    check("mid_rst_req", {31'b0, imem_req}, 32'h0);
    check("mid_rst_pc", pc, 32'h0000_3000);
    check("mid_rst_cnt", retired_cnt, 32'h0);
    step();
    check("mid_rst_pc_edge", pc, 32'h0000_3000);
    retire = 1'b0;
    Branch = 1'b0;
    Zero = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
